ttt_turn_scheduler: RTL and testbench
=====================================

# ttt_turn_scheduler

Game sequencer for the tic-tac-toe design. Takes single-cycle "next cell" and "select cell" button pulses, owns the 3x3 board state, cursor and turn, and arbitrates moves between player X and player O. Detects win and draw, and supports restart. Its outputs feed the VGA video controller directly: per-cell sprite codes, and a highlight index (cursor, or 4'hF when not playing).

## Interface
Parameters:
- TIMEOUT_CYCLES, default 500000000: turn time limit in CLOCK_50 cycles (10 s). Used only when the timeout feature is compiled in.
- TW, default 29: timeout counter width. Must satisfy 2^TW > TIMEOUT_CYCLES.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- btn_next  in  1  one-cycle pulse, already debounced and synchronised; advance cursor
- btn_select  in  1  one-cycle pulse, already debounced and synchronised; place mark, or restart in DONE
- cursor  out  4  current cell index, 0..8, row-major (cell 0 = block 00, cell 8 = block 22)
- board  out  18  cell i at bits [2i+1:2i]; 00 empty, 01 X, 10 O; 11 never driven
- turn  out  1  0 = X to move, 1 = O to move
- result  out  2  00 playing, 01 X wins, 10 O wins, 11 draw
- highlight  out  4  equals cursor in PLAY/CHECK; 4'hF in DONE
- move_valid  out  1  one-cycle pulse when a mark is written
- move_reject  out  1  one-cycle pulse when select targets an occupied cell
- timeout_pulse  out  1  one-cycle pulse when an automatic move is forced

## Operation
- States: PLAY, CHECK, DONE.
- Reset values: state PLAY; board 0; cursor 0; turn 0; result 00; move count 0; all pulses 0; highlight 0.
- PLAY, btn_next only: cursor increments; 8 wraps to 0.
- PLAY, btn_select on an empty cell: the mark for `turn` is written at `cursor`; move_valid pulses; move count +1; go to CHECK.
- PLAY, btn_select on an occupied cell: board unchanged; move_reject pulses; stay in PLAY.
- btn_next and btn_select in the same cycle: select takes priority; next is dropped and the cursor does not move.
- CHECK (exactly one cycle), evaluating the 8 lines (3 rows, 3 columns, 2 diagonals) on the updated board:
  - Line complete for the mover: result = 01 (X) or 10 (O); go to DONE.
  - Otherwise, move count = 9: result = 11; go to DONE.
  - Otherwise: turn toggles; go to PLAY. Cursor is retained.
- Button pulses arriving in CHECK are ignored.
- DONE:
  - btn_next is ignored.
  - btn_select restarts: board, cursor, turn, result and move count return to their reset values; go to PLAY. No move_valid pulse.
  - turn holds the winner's or last mover's value until restart.
- Reset asserted mid-game or mid-CHECK: immediate return to the reset values. No partial write survives.

## Timing
- btn_select sampled at edge N:
  - board, move_valid and move_reject valid after edge N; state is CHECK.
  - result and turn update after edge N+1.
- Earliest next move is sampled at edge N+2.
- btn_next sampled at edge N: cursor updates after edge N.
- All outputs are registered; none are combinational from the inputs.

## Configuration
- TTT_TURN_TIMEOUT_EN defined:
  - A TW-bit counter clears on reset, on entry to PLAY and on every accepted move.
  - It increments each cycle in PLAY.
  - When it reaches TIMEOUT_CYCLES-1 with no select that cycle, the mover's mark is placed in the lowest-index empty cell; cursor jumps there. timeout_pulse and move_valid pulse together, then go to CHECK.
  - A select in the same cycle as the expiry takes priority; no forced move.
- TTT_TURN_TIMEOUT_EN not defined: no counter is implemented; timeout_pulse is tied to 0.

## Structure
- Package ttt_pkg holds:
  - cell_t (2-bit: EMPTY, X, O)
  - result_t (PLAYING, X_WIN, O_WIN, DRAW)
  - state_t (PLAY, CHECK, DONE)
  - WIN_LINES constant: 8 triples of cell indices
  - NUM_CELLS = 9, HIGHLIGHT_NONE = 4'hF
- Sub-module ttt_win_detect: combinational. Inputs: board and a player code. Output: 1-bit "line complete". Instantiated once, for the mover.

## Test plan
- Reset, then 9 btn_next pulses -> cursor steps through 1..8 and returns to 0; board = 0; highlight = cursor.
- Moves X@0, O@3, X@1, O@4, X@2 -> result = 01 two cycles after the fifth select; highlight = 4'hF; further btn_next leaves the cursor unchanged.
- Select on occupied cell 0 after X@0 -> move_reject = 1 for one cycle; board[1:0] stays 01; turn is unchanged.
- Full board with no line (X0 O1 X2 X3 O4 O5 O6 X7 X8, legal order) -> result = 11 after the 9th move; then btn_select -> board = 0, turn = 0, result = 00.
- btn_next and btn_select in the same cycle at cursor 2 -> mark written at cell 2; cursor stays 2.
- With TTT_TURN_TIMEOUT_EN and TIMEOUT_CYCLES = 20, cells 0 and 1 occupied, no input -> after 20 PLAY cycles: timeout_pulse = 1, mark at cell 2, cursor = 2. Separately: rst asserted mid-countdown -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn scheduler.
package ttt_pkg;

    localparam int unsigned NUM_CELLS      = 9;
    localparam logic [3:0]  HIGHLIGHT_NONE = 4'hF;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        X     = 2'b01,
        O     = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        PLAYING = 2'b00,
        X_WIN   = 2'b01,
        O_WIN   = 2'b10,
        DRAW    = 2'b11
    } result_t;

    typedef enum logic [1:0] {
        PLAY  = 2'b00,
        CHECK = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Three rows, three columns, two diagonals (row-major cell indices).
    localparam logic [3:0] WIN_LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // Mark placed by the player whose turn it is (turn 0 = X).
    function automatic cell_t mark_of(input logic turn);
        return turn ? O : X;
    endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational line detector: flags when any of the eight lines is fully
// owned by the given player.
module ttt_win_detect
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    input  cell_t       player,
    output logic        line_done
);

    // OR across all lines of "all three cells equal player".
    always_comb begin
        line_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (board[2*WIN_LINES[i][0] +: 2] == player &&
                board[2*WIN_LINES[i][1] +: 2] == player &&
                board[2*WIN_LINES[i][2] +: 2] == player) begin
                line_done = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttt_turn_scheduler.sv
// Tic-tac-toe game sequencer: owns board, cursor and turn, arbitrates moves,
// detects win/draw and handles restart. All outputs are registered.
// Optional turn time limit compiled in with `define TTT_TURN_TIMEOUT_EN.
module ttt_turn_scheduler
    import ttt_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 500000000,
    parameter int unsigned TW             = 29
) (
    input  logic        CLOCK_50,
    input  logic        rst,
    input  logic        btn_next,
    input  logic        btn_select,
    output logic [3:0]  cursor,
    output logic [17:0] board,
    output logic        turn,
    output logic [1:0]  result,
    output logic [3:0]  highlight,
    output logic        move_valid,
    output logic        move_reject,
    output logic        timeout_pulse
);

    if (64'(TIMEOUT_CYCLES) >= (64'd1 << TW)) begin : g_tw_check
        $error("TW is too narrow to hold TIMEOUT_CYCLES");
    end

    state_t      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic [3:0]  cursor_q, cursor_d;
    logic        turn_q, turn_d;
    result_t     result_q, result_d;
    logic [3:0]  moves_q, moves_d;
    logic [3:0]  highlight_q, highlight_d;
    logic        move_valid_q, move_valid_d;
    logic        move_reject_q, move_reject_d;
    logic        line_done;
    logic [4:0]  cursor_lsb;

    assign cursor_lsb = {cursor_q, 1'b0};

    // Only the player who just moved can have completed a line.
    ttt_win_detect u_win_detect (
        .board     (board_q),
        .player    (mark_of(turn_q)),
        .line_done (line_done)
    );

`ifdef TTT_TURN_TIMEOUT_EN
    logic [TW-1:0] timer_q;
    logic          timeout_pulse_q, timeout_pulse_d;
    logic          expired;
    logic [3:0]    low_empty;
    logic [4:0]    low_empty_lsb;

    // Turn timer: counts PLAY cycles, zero everywhere else so it restarts on
    // every entry to PLAY (an accepted move always leaves PLAY).
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else if (state_q == PLAY) begin
            timer_q <= timer_q + 1'b1;
        end else begin
            timer_q <= '0;
        end
    end

    // >= keeps the expiry armed if a rejected select lands on the expiry cycle.
    assign expired = (timer_q >= TW'(TIMEOUT_CYCLES - 1));

    // Lowest-index empty cell; one always exists while in PLAY.
    always_comb begin
        low_empty = 4'd0;
        for (int i = NUM_CELLS - 1; i >= 0; i--) begin
            if (board_q[2*i +: 2] == EMPTY) begin
                low_empty = 4'(i);
            end
        end
    end

    assign low_empty_lsb = {low_empty, 1'b0};
    assign timeout_pulse = timeout_pulse_q;
`else
    assign timeout_pulse = 1'b0;
`endif

    // Next-state and registered-output computation for the game FSM.
    always_comb begin
        state_d       = state_q;
        board_d       = board_q;
        cursor_d      = cursor_q;
        turn_d        = turn_q;
        result_d      = result_q;
        moves_d       = moves_q;
        move_valid_d  = 1'b0;
        move_reject_d = 1'b0;
`ifdef TTT_TURN_TIMEOUT_EN
        timeout_pulse_d = 1'b0;
`endif
        unique case (state_q)
            PLAY: begin
                if (btn_select) begin
                    // Select wins over a simultaneous next or an expiring timer.
                    if (board_q[cursor_lsb +: 2] == EMPTY) begin
                        board_d[cursor_lsb +: 2] = mark_of(turn_q);
                        move_valid_d = 1'b1;
                        moves_d      = moves_q + 4'd1;
                        state_d      = CHECK;
                    end else begin
                        move_reject_d = 1'b1;
                    end
`ifdef TTT_TURN_TIMEOUT_EN
                end else if (expired) begin
                    board_d[low_empty_lsb +: 2] = mark_of(turn_q);
                    cursor_d        = low_empty;
                    move_valid_d    = 1'b1;
                    timeout_pulse_d = 1'b1;
                    moves_d         = moves_q + 4'd1;
                    state_d         = CHECK;
`endif
                end else if (btn_next) begin
                    cursor_d = (cursor_q == 4'(NUM_CELLS - 1)) ? 4'd0 : cursor_q + 4'd1;
                end
            end
            CHECK: begin
                if (line_done) begin
                    result_d = turn_q ? O_WIN : X_WIN;
                    state_d  = DONE;
                end else if (moves_q == 4'(NUM_CELLS)) begin
                    result_d = DRAW;
                    state_d  = DONE;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = PLAY;
                end
            end
            DONE: begin
                if (btn_select) begin
                    board_d  = '0;
                    cursor_d = 4'd0;
                    turn_d   = 1'b0;
                    result_d = PLAYING;
                    moves_d  = 4'd0;
                    state_d  = PLAY;
                end
            end
            default: begin
                state_d = PLAY;
            end
        endcase
        highlight_d = (state_d == DONE) ? HIGHLIGHT_NONE : cursor_d;
    end

    // Game state registers.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q       <= PLAY;
            board_q       <= '0;
            cursor_q      <= 4'd0;
            turn_q        <= 1'b0;
            result_q      <= PLAYING;
            moves_q       <= 4'd0;
            highlight_q   <= 4'd0;
            move_valid_q  <= 1'b0;
            move_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            board_q       <= board_d;
            cursor_q      <= cursor_d;
            turn_q        <= turn_d;
            result_q      <= result_d;
            moves_q       <= moves_d;
            highlight_q   <= highlight_d;
            move_valid_q  <= move_valid_d;
            move_reject_q <= move_reject_d;
        end
    end

`ifdef TTT_TURN_TIMEOUT_EN
    // Forced-move strobe register.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            timeout_pulse_q <= 1'b0;
        end else begin
            timeout_pulse_q <= timeout_pulse_d;
        end
    end
`endif

    assign cursor      = cursor_q;
    assign board       = board_q;
    assign turn        = turn_q;
    assign result      = result_q;
    assign highlight   = highlight_q;
    assign move_valid  = move_valid_q;
    assign move_reject = move_reject_q;

endmodule

// File: tb/tb_ttt_turn_scheduler.sv
// Scoreboard bench for ttt_turn_scheduler: the driver updates a plain game
// model and queues the expected response to every select; a monitor pops and
// compares whenever move_valid or move_reject fires.
module tb_ttt_turn_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_next = 1'b0;
    logic        btn_select = 1'b0;
    logic [3:0]  cursor;
    logic [17:0] board;
    logic        turn;
    logic [1:0]  result;
    logic [3:0]  highlight;
    logic        move_valid;
    logic        move_reject;
    logic        timeout_pulse;

    ttt_turn_scheduler #(.TIMEOUT_CYCLES(1000), .TW(10)) dut (
        .CLOCK_50      (clk),
        .rst           (rst),
        .btn_next      (btn_next),
        .btn_select    (btn_select),
        .cursor        (cursor),
        .board         (board),
        .turn          (turn),
        .result        (result),
        .highlight     (highlight),
        .move_valid    (move_valid),
        .move_reject   (move_reject),
        .timeout_pulse (timeout_pulse)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit          rej;
        logic [17:0] board;
        logic [3:0]  cur;
        logic        turn_now;
        logic        tp;
        logic [1:0]  res_after;
        logic        turn_after;
        logic [3:0]  hl_after;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: cells hold 0 empty, 1 X, 2 O.
    int mb[9];
    int mcur, mturn, mmoves, mres;
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] pack();
        logic [17:0] p;
        for (int i = 0; i < 9; i++) p[2*i +: 2] = 2'(mb[i]);
        return p;
    endfunction

    function automatic bit model_win(int m);
        for (int l = 0; l < 8; l++)
            if (mb[lines[l][0]] == m && mb[lines[l][1]] == m && mb[lines[l][2]] == m)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_restart();
        for (int i = 0; i < 9; i++) mb[i] = 0;
        mcur = 0; mturn = 0; mmoves = 0; mres = 0;
    endtask

    // Model placing the mover's mark at cell c; returns the expectation.
    task automatic model_place(input int c, input bit tp, output exp_t e);
        mb[c] = mturn + 1;
        mmoves++;
        mcur = c;
        e.rej = 1'b0; e.board = pack(); e.cur = 4'(c); e.turn_now = 1'(mturn); e.tp = tp;
        if (model_win(mturn + 1)) mres = (mturn != 0) ? 2 : 1;
        else if (mmoves == 9) mres = 3;
        else mturn ^= 1;
        e.res_after = 2'(mres); e.turn_after = 1'(mturn);
        e.hl_after = (mres != 0) ? 4'hF : 4'(mcur);
    endtask

    // One-cycle button pulse; optionally keeps next high into the CHECK cycle.
    task automatic pulse(bit n, bit s, bit hold_next);
        @(negedge clk); btn_next = n; btn_select = s;
        @(negedge clk); btn_select = 1'b0; btn_next = hold_next;
        if (hold_next) begin
            @(negedge clk); btn_next = 1'b0;
        end
    endtask

    task automatic press(bit n, bit s);
        exp_t e;
        bit   hold;
        hold = 1'b0;
        if (mres != 0) begin
            if (s) model_restart();
            pulse(n, s, 1'b0);
            chk("done_cursor", cursor, mcur);
            chk("done_board", board, pack());
            chk("done_result", result, mres);
            chk("done_turn", turn, mturn);
            chk("done_highlight", highlight, (mres != 0) ? 15 : mcur);
            return;
        end
        if (s) begin
            if (mb[mcur] != 0) begin
                e.rej = 1'b1; e.board = pack(); e.cur = 4'(mcur); e.turn_now = 1'(mturn);
                e.tp = 1'b0; e.res_after = 2'(mres); e.turn_after = 1'(mturn);
                e.hl_after = 4'(mcur);
                q.push_back(e);
            end else begin
                model_place(mcur, 1'b0, e);
                q.push_back(e);
                hold = ($urandom_range(0, 3) == 0);
            end
            pulse(n, s, hold);
        end else begin
            if (n) mcur = (mcur == 8) ? 0 : mcur + 1;
            pulse(n, 1'b0, 1'b0);
            chk("cursor", cursor, mcur);
            chk("highlight_play", highlight, mcur);
        end
    endtask

    task automatic play_to(int c);
        for (int k = 0; k < 9 && mcur != c; k++) press(1'b1, 1'b0);
        press(1'b0, 1'b1);
    endtask

    // Async reset between clock edges; outputs must clear before any edge.
    task automatic do_reset();
        repeat (2) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_cursor", cursor, 0);
        chk("rst_board", board, 0);
        chk("rst_turn", turn, 0);
        chk("rst_result", result, 0);
        chk("rst_highlight", highlight, 0);
        chk("rst_pulses", {move_valid, move_reject, timeout_pulse}, 0);
        q.delete();
        model_restart();
        @(negedge clk); rst = 1'b0;
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (!rst && (move_valid || move_reject)) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {move_valid, move_reject}, 0);
                end else begin
                    e = q.pop_front();
                    chk("pulse_kind", {move_valid, move_reject}, e.rej ? 2'b01 : 2'b10);
                    chk("board", board, e.board);
                    chk("move_cursor", cursor, e.cur);
                    chk("turn_at_move", turn, e.turn_now);
                    chk("timeout_pulse", timeout_pulse, e.tp);
                    if (!e.rej) begin
                        @(posedge clk); #1;
                        chk("result", result, e.res_after);
                        chk("turn_after", turn, e.turn_after);
                        chk("highlight_after", highlight, e.hl_after);
                    end
                end
            end
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        bit   seen;
        int   r;
        model_restart();
        #25;
        chk("reset_cursor", cursor, 0);
        chk("reset_board", board, 0);
        chk("reset_result", result, 0);
        chk("reset_highlight", highlight, 0);
        @(negedge clk); rst = 1'b0;

        // Cursor walk with wrap.
        for (int i = 0; i < 9; i++) press(1'b1, 1'b0);
        chk("walk_board", board, 0);

        // X wins on the top row; next in DONE is ignored; select restarts.
        play_to(0); play_to(3); play_to(1); play_to(4); play_to(2);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);

        // Select on an occupied cell.
        play_to(0);
        press(1'b0, 1'b1);
        do_reset();

        // Draw, then restart.
        play_to(0); play_to(1); play_to(2); play_to(4); play_to(3);
        play_to(5); play_to(7); play_to(6); play_to(8);
        press(1'b0, 1'b1);

        // Next and select together at cursor 2.
        press(1'b1, 1'b0); press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        chk("both_cursor", cursor, 2);
        do_reset();

        // Idle turn: forced move with the feature, nothing without it.
        play_to(0); play_to(1);
`ifdef TTT_TURN_TIMEOUT_EN
        model_place(2, 1'b1, e);
        q.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 1100 && !seen; i++) begin
            @(posedge clk); #1;
            if (move_valid) seen = 1'b1;
        end
        chk("timeout_seen", seen, 1);
        repeat (3) @(negedge clk);
`else
        repeat (1100) @(negedge clk);
        chk("no_forced_board", board, pack());
        chk("no_forced_turn", turn, mturn);
        seen = 1'b0;
`endif
        do_reset();

        // Random games, with one mid-game reset.
        for (int g = 0; g < 6; g++) begin
            for (int k = 0; k < 300 && mres == 0; k++) begin
                r = $urandom_range(0, 9);
                if (r < 5) press(1'b1, 1'b0);
                else if (r < 8) press(1'b0, 1'b1);
                else if (r == 8) press(1'b1, 1'b1);
                else press(1'b0, 1'b0);
                if (g == 2 && k == 20) do_reset();
            end
            chk("game_finished", (mres != 0), 1);
            press(1'b1, 1'b0);
            press(1'b0, 1'b1);
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
